// File: rtl/bolme_birimi_p.sv
// Iterative signed/unsigned integer divider (DIV/DIVU/REM/REMU), restoring algorithm, ADIM_BIT quotient bits per cycle.
// Optional result cache for back-to-back quotient/remainder requests on the same operands: define BOLME_ONBELLEK_EN.
module bolme_birimi_p #(
   parameter int VERI_BIT = 32,
   parameter int ADIM_BIT = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                gecerli_i,
   input  logic [1:0]          islem_i,
   input  logic [VERI_BIT-1:0] bolunen_i,
   input  logic [VERI_BIT-1:0] bolen_i,
   input  logic                durdur_i,
   input  logic                iptal_i,
   output logic                hazir_o,
   output logic                sonuc_gecerli_o,
   output logic [VERI_BIT-1:0] sonuc_o
);
   localparam int K     = VERI_BIT / ADIM_BIT;
   localparam int SAY_W = $clog2(K);
   localparam logic [VERI_BIT-1:0] EN_NEG = {1'b1, {(VERI_BIT-1){1'b0}}};

   typedef enum logic [1:0] {BOSTA = 2'd0, HESAPLA = 2'd1, DUZELT = 2'd2, BITTI = 2'd3} durum_t;

   durum_t              durum_q, durum_d;
   logic [VERI_BIT-1:0] kalan_q, kalan_d, bolum_q, bolum_d, bolen_q, bolen_d, sonuc_q, sonuc_d;
   logic [SAY_W-1:0]    sayac_q, sayac_d;
   logic                q_isaret_q, q_isaret_d, r_isaret_q, r_isaret_d;
   logic                ozel_q, ozel_d, kalan_sec_q, kalan_sec_d;

   logic                isaretli, a_neg, b_neg, sifir_bolen, tasma, isabet;
   logic [VERI_BIT-1:0] a_mag, b_mag, son_bolum, son_kalan;
   logic [VERI_BIT-1:0] adim_kalan, adim_bolum;
   logic [VERI_BIT:0]   genis;

`ifdef BOLME_ONBELLEK_EN
   logic                onb_gecerli_q, onb_gecerli_d, onb_isaretli_q, onb_isaretli_d;
   logic [VERI_BIT-1:0] onb_bolunen_q, onb_bolunen_d, onb_bolen_q, onb_bolen_d;
   logic [VERI_BIT-1:0] onb_bolum_q, onb_bolum_d, onb_kalan_q, onb_kalan_d;
`endif

   always_comb begin
      isaretli    = ~islem_i[0];
      a_neg       = isaretli & bolunen_i[VERI_BIT-1];
      b_neg       = isaretli & bolen_i[VERI_BIT-1];
      a_mag       = a_neg ? -bolunen_i : bolunen_i;
      b_mag       = b_neg ? -bolen_i : bolen_i;
      sifir_bolen = (bolen_i == '0);
      tasma       = isaretli && (bolunen_i == EN_NEG) && (bolen_i == '1);
`ifdef BOLME_ONBELLEK_EN
      isabet = onb_gecerli_q && (bolunen_i == onb_bolunen_q) && (bolen_i == onb_bolen_q) &&
               (isaretli == onb_isaretli_q);
`else
      isabet = 1'b0;
`endif
   end

   // one restoring step per retired quotient bit; the dividend shifts out of bolum as quotient bits shift in
   always_comb begin
      adim_kalan = kalan_q;
      adim_bolum = bolum_q;
      genis      = '0;
      for (int i = 0; i < ADIM_BIT; i++) begin
         genis      = {adim_kalan, adim_bolum[VERI_BIT-1]};
         adim_bolum = {adim_bolum[VERI_BIT-2:0], 1'b0};
         if (genis >= {1'b0, bolen_q}) begin
            genis         = genis - {1'b0, bolen_q};
            adim_bolum[0] = 1'b1;
         end
         adim_kalan = genis[VERI_BIT-1:0];
      end
   end

   // special and cached results are preloaded already sign-correct
   always_comb begin
      son_bolum = (!ozel_q && q_isaret_q) ? -bolum_q : bolum_q;
      son_kalan = (!ozel_q && r_isaret_q) ? -kalan_q : kalan_q;
   end

   always_comb begin
      durum_d     = durum_q;
      kalan_d     = kalan_q;
      bolum_d     = bolum_q;
      bolen_d     = bolen_q;
      sonuc_d     = sonuc_q;
      sayac_d     = sayac_q;
      q_isaret_d  = q_isaret_q;
      r_isaret_d  = r_isaret_q;
      ozel_d      = ozel_q;
      kalan_sec_d = kalan_sec_q;
`ifdef BOLME_ONBELLEK_EN
      onb_gecerli_d  = onb_gecerli_q;
      onb_isaretli_d = onb_isaretli_q;
      onb_bolunen_d  = onb_bolunen_q;
      onb_bolen_d    = onb_bolen_q;
      onb_bolum_d    = onb_bolum_q;
      onb_kalan_d    = onb_kalan_q;
`endif
      case (durum_q)
         BOSTA: begin
            if (gecerli_i && !iptal_i) begin
               kalan_sec_d = islem_i[1];
               q_isaret_d  = a_neg ^ b_neg;
               r_isaret_d  = a_neg;
               bolen_d     = b_mag;
               bolum_d     = a_mag;
               kalan_d     = '0;
               sayac_d     = '0;
               ozel_d      = 1'b1;
               durum_d     = DUZELT;
`ifdef BOLME_ONBELLEK_EN
               onb_gecerli_d  = 1'b0;
               onb_isaretli_d = isaretli;
               onb_bolunen_d  = bolunen_i;
               onb_bolen_d    = bolen_i;
`endif
               if (sifir_bolen) begin
                  bolum_d = '1;
                  kalan_d = bolunen_i;
               end else if (tasma) begin
                  bolum_d = EN_NEG;
               end else if (isabet) begin
`ifdef BOLME_ONBELLEK_EN
                  bolum_d = onb_bolum_q;
                  kalan_d = onb_kalan_q;
`endif
               end else begin
                  ozel_d  = 1'b0;
                  durum_d = HESAPLA;
               end
            end
         end
         HESAPLA: begin
            kalan_d = adim_kalan;
            bolum_d = adim_bolum;
            sayac_d = sayac_q + 1'b1;
            if (sayac_q == SAY_W'(K - 1)) durum_d = DUZELT;
         end
         DUZELT: begin
            sonuc_d = kalan_sec_q ? son_kalan : son_bolum;
            durum_d = BITTI;
`ifdef BOLME_ONBELLEK_EN
            onb_gecerli_d = 1'b1;
            onb_bolum_d   = son_bolum;
            onb_kalan_d   = son_kalan;
`endif
         end
         BITTI: begin
            if (!durdur_i) durum_d = BOSTA;
         end
         default: durum_d = BOSTA;
      endcase
      if (iptal_i) begin
         durum_d = BOSTA;
`ifdef BOLME_ONBELLEK_EN
         onb_gecerli_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         durum_q     <= BOSTA;
         kalan_q     <= '0;
         bolum_q     <= '0;
         bolen_q     <= '0;
         sonuc_q     <= '0;
         sayac_q     <= '0;
         q_isaret_q  <= 1'b0;
         r_isaret_q  <= 1'b0;
         ozel_q      <= 1'b0;
         kalan_sec_q <= 1'b0;
`ifdef BOLME_ONBELLEK_EN
         onb_gecerli_q  <= 1'b0;
         onb_isaretli_q <= 1'b0;
         onb_bolunen_q  <= '0;
         onb_bolen_q    <= '0;
         onb_bolum_q    <= '0;
         onb_kalan_q    <= '0;
`endif
      end else begin
         durum_q     <= durum_d;
         kalan_q     <= kalan_d;
         bolum_q     <= bolum_d;
         bolen_q     <= bolen_d;
         sonuc_q     <= sonuc_d;
         sayac_q     <= sayac_d;
         q_isaret_q  <= q_isaret_d;
         r_isaret_q  <= r_isaret_d;
         ozel_q      <= ozel_d;
         kalan_sec_q <= kalan_sec_d;
`ifdef BOLME_ONBELLEK_EN
         onb_gecerli_q  <= onb_gecerli_d;
         onb_isaretli_q <= onb_isaretli_d;
         onb_bolunen_q  <= onb_bolunen_d;
         onb_bolen_q    <= onb_bolen_d;
         onb_bolum_q    <= onb_bolum_d;
         onb_kalan_q    <= onb_kalan_d;
`endif
      end
   end

   assign hazir_o         = (durum_q == BOSTA);
   assign sonuc_gecerli_o = (durum_q == BITTI);
   assign sonuc_o         = sonuc_q;
endmodule

// File: tb/tb_bolme_birimi_p.sv
// Scoreboard bench for bolme_birimi_p: one 32/1 instance and one 32/4 instance.
module tb_bolme_birimi_p;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        g0 = 1'b0, g1 = 1'b0;
   logic [1:0]  islem = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic        durdur = 1'b0, iptal = 1'b0;
   logic        h0, v0, h1, v1;
   logic [31:0] s0, s1;

   int n_chk = 0, n_pass = 0, cyc = 0;

`ifdef BOLME_ONBELLEK_EN
   localparam bit ONB = 1'b1;
`else
   localparam bit ONB = 1'b0;
`endif

   bolme_birimi_p #(.VERI_BIT(32), .ADIM_BIT(1)) u0 (
      .clk_i(clk), .rst_i(rst), .gecerli_i(g0), .islem_i(islem), .bolunen_i(a), .bolen_i(b),
      .durdur_i(durdur), .iptal_i(iptal), .hazir_o(h0), .sonuc_gecerli_o(v0), .sonuc_o(s0));

   bolme_birimi_p #(.VERI_BIT(32), .ADIM_BIT(4)) u1 (
      .clk_i(clk), .rst_i(rst), .gecerli_i(g1), .islem_i(islem), .bolunen_i(a), .bolen_i(b),
      .durdur_i(durdur), .iptal_i(iptal), .hazir_o(h1), .sonuc_gecerli_o(v1), .sonuc_o(s1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] val;
      int          cyc;
      int          w;
      bit          dut;
      string       nm;
   } item_t;
   item_t sb[$];

   // expected-cache model for instance u0
   bit          m_valid = 1'b0, m_s = 1'b0;
   logic [31:0] m_a = '0, m_b = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   function automatic int lat0(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      bit s = ~op[0];
      if (y == 32'd0) return 1;
      if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      if (ONB && m_valid && m_a == x && m_b == y && m_s == s) return 1;
      return 33;
   endfunction

   // called at a negedge; drives one request that is accepted at the next rising edge
   task automatic issue(input bit d, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit push, input logic [31:0] exp, input int w, input string nm);
      int l;
      l = d ? 9 : lat0(op, x, y);
      islem = op; a = x; b = y;
      if (d) g1 = 1'b1; else g0 = 1'b1;
      @(posedge clk);
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (push) sb.push_back('{val: exp, cyc: cyc + l, w: w, dut: d, nm: nm});
      if (!d) begin
         m_valid = push;
         m_a = x; m_b = y; m_s = ~op[0];
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (h0 && h1 && !v0 && !v1) begin ok = 1'b1; break; end
      end
      chk("idle_timeout", 32'(ok), 32'd1);
   endtask

   task automatic run(input bit d, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp, input string nm);
      issue(d, op, x, y, 1'b1, exp, 1, nm);
      wait_idle();
   endtask

   // monitor: pops on each rising result-valid and checks latency, value, and pulse width
   bit    pv = 1'b0, active = 1'b0;
   int    wcnt = 0;
   item_t cur;
   always @(negedge clk) begin
      logic        mv;
      logic [31:0] ms;
      mv = v0 | v1;
      ms = v1 ? s1 : s0;
      if (mv) begin
         if (!pv) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_result: got 0x%08h at cycle %0d, required no result", ms, cyc);
               active = 1'b0;
            end else begin
               cur = sb.pop_front();
               active = 1'b1;
               wcnt = 0;
               chk({cur.nm, "_latency"}, 32'(cyc), 32'(cur.cyc));
               chk({cur.nm, "_instance"}, 32'(v1), 32'(cur.dut));
            end
         end
         if (active) begin
            chk(cur.nm, ms, cur.val);
            wcnt++;
         end
      end else if (pv && active) begin
         chk({cur.nm, "_width"}, 32'(wcnt), 32'(cur.w));
         active = 1'b0;
      end
      pv = mv;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_hazir0", 32'(h0), 32'd1);
      chk("rst_vld0", 32'(v0), 32'd0);
      chk("rst_sonuc0", s0, 32'd0);
      chk("rst_hazir1", 32'(h1), 32'd1);
      chk("rst_sonuc1", s1, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      run(0, 2'b00, 32'd40, 32'd10, 32'd4, "div_40_10");
      run(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
      run(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
      run(0, 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
      run(0, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2");
      run(0, 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, "div_minneg_2");
      run(0, 2'b01, 32'd400, 32'd3, 32'h85, "divu_400_3");
      run(0, 2'b11, 32'd400, 32'd3, 32'd1, "remu_400_3");

      // flush while idle invalidates any stored result
      iptal = 1'b1;
      @(negedge clk);
      iptal = 1'b0;
      m_valid = 1'b0;
      run(0, 2'b11, 32'd400, 32'd3, 32'd1, "remu_after_iptal");

      run(0, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
      run(0, 2'b10, 32'd5, 32'd0, 32'd5, "rem_by_zero");
      run(0, 2'b01, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
      run(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
      run(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");

      // stall holds the result for the stall length plus one cycle
      durdur = 1'b1;
      issue(0, 2'b01, 32'd400, 32'd3, 1'b1, 32'h85, 6, "divu_stall");
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (v0) break;
      end
      repeat (5) @(negedge clk);
      durdur = 1'b0;
      @(negedge clk);
      chk("hazir_after_stall", 32'(h0), 32'd1);
      chk("vld_after_stall", 32'(v0), 32'd0);

      // flush at cycle 10 of an operation
      issue(0, 2'b01, 32'd1000, 32'd7, 1'b0, 32'd0, 0, "aborted");
      repeat (9) @(negedge clk);
      iptal = 1'b1;
      @(negedge clk);
      iptal = 1'b0;
      chk("hazir_after_iptal", 32'(h0), 32'd1);
      repeat (40) @(negedge clk);

      // flush wins over a simultaneous request
      islem = 2'b00; a = 32'd40; b = 32'd10;
      iptal = 1'b1; g0 = 1'b1;
      @(posedge clk);
      #1;
      g0 = 1'b0; iptal = 1'b0;
      m_valid = 1'b0;
      @(negedge clk);
      chk("hazir_iptal_gecerli", 32'(h0), 32'd1);
      repeat (40) @(negedge clk);

      // reset mid-operation, request accepted on the release edge
      issue(0, 2'b01, 32'd1000, 32'd7, 1'b0, 32'd0, 0, "aborted_rst");
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_hazir", 32'(h0), 32'd1);
      chk("midrst_vld", 32'(v0), 32'd0);
      chk("midrst_sonuc", s0, 32'd0);
      m_valid = 1'b0;
      rst = 1'b1;
      issue(0, 2'b00, 32'd40, 32'd10, 1'b1, 32'd4, 1, "div_after_rst");
      wait_idle();

      run(1, 2'b01, 32'hFFFF_FFFF, 32'd7, 32'h2492_4924, "divu_adim4");

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/bolme_birimi_p.md
BOLME_BIRIMI_P -- requirements
Module: bolme_birimi_p

Interface
REQ-001 The block SHALL have parameter VERI_BIT, default 32, operand and result width (even, >=8).
REQ-002 The block SHALL have parameter ADIM_BIT, default 1, quotient bits retired per cycle (1, 2 or 4; must divide VERI_BIT).
REQ-003 The block SHALL have port clk_i  input  1  the single clock, rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port gecerli_i  input  1  request valid.
REQ-006 The block SHALL have port islem_i  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 The block SHALL have port bolunen_i  input  VERI_BIT  dividend.
REQ-008 The block SHALL have port bolen_i  input  VERI_BIT  divisor.
REQ-009 The block SHALL have port durdur_i  input  1  downstream stall; hold the result while high.
REQ-010 The block SHALL have port iptal_i  input  1  flush; abandon the operation in flight.
REQ-011 The block SHALL have port hazir_o  output  1  ready to accept a request.
REQ-012 The block SHALL have port sonuc_gecerli_o  output  1  result valid.
REQ-013 The block SHALL have port sonuc_o  output  VERI_BIT  quotient or remainder.

Function
REQ-014 The FSM SHALL have states BOSTA, HESAPLA, DUZELT and BITTI; hazir_o SHALL be 1 only in BOSTA.
REQ-015 In BOSTA, gecerli_i=1 SHALL latch the operands and islem_i (the accepting edge is edge 0) and move the FSM to HESAPLA; gecerli_i outside BOSTA SHALL be ignored.
REQ-016 The signed ops (DIV/REM) SHALL take operand magnitudes at acceptance and record the quotient sign (sign XOR) and remainder sign (dividend sign).
REQ-017 HESAPLA SHALL run restoring division for K=VERI_BIT/ADIM_BIT cycles, retiring ADIM_BIT quotient bits per cycle, then move to DUZELT.
REQ-018 DUZELT SHALL apply the two's-complement sign fix and select the quotient (DIV/DIVU) or remainder (REM/REMU); sonuc_gecerli_o SHALL be 1 after edge K+1.
REQ-019 Divide-by-zero SHALL skip HESAPLA and go straight to BITTI: quotient all-ones, remainder = dividend, result after edge 1.
REQ-020 Signed overflow (dividend = most-negative value, divisor = -1) SHALL skip HESAPLA: quotient = most-negative value, remainder 0, result after edge 1.
REQ-021 In BITTI, sonuc_o and sonuc_gecerli_o SHALL hold stable while durdur_i=1; the first edge with durdur_i=0 SHALL return the FSM to BOSTA and clear sonuc_gecerli_o.
REQ-022 With durdur_i=0, sonuc_gecerli_o SHALL be exactly one cycle wide.
REQ-023 iptal_i=1 in any state SHALL force BOSTA on the next edge, with sonuc_gecerli_o=0 and no result delivered.
REQ-024 iptal_i SHALL have priority over gecerli_i when both are high in BOSTA: no request is accepted.

Reset
REQ-025 rst_i=0 at a rising edge SHALL force BOSTA with hazir_o=1, sonuc_gecerli_o=0 and sonuc_o=0, and SHALL clear all internal registers.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no result; the first edge after release SHALL be able to accept a request.

Configuration
REQ-027 The block SHALL support the macro BOLME_ONBELLEK_EN.
REQ-028 With BOLME_ONBELLEK_EN defined, the block SHALL store the last completed operands, signedness, quotient and remainder.
REQ-029 With BOLME_ONBELLEK_EN defined, a request matching the stored operands and signedness SHALL go straight to BITTI and return the other result after edge 1 (e.g. DIV followed by REM on the same operands).
REQ-030 With BOLME_ONBELLEK_EN defined, the cache SHALL be invalidated by reset, by iptal_i, and by any aborted operation.
REQ-031 Without BOLME_ONBELLEK_EN, every non-special request SHALL take the full K+1 latency and the cache storage SHALL not be built.

Verification (VERI_BIT=32, ADIM_BIT=1 unless stated)
REQ-032 DIV 40/10 -> sonuc_o=4, sonuc_gecerli_o high after edge 33 for one cycle.
REQ-033 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 400/3 -> 0x85; REMU 400/3 -> 1.
REQ-034 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each after edge 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after edge 1.
REQ-035 DIVU 400/3 with durdur_i=1 for 5 cycles at completion -> result held 6 cycles, then hazir_o=1; iptal_i at cycle 10 of an operation -> BOSTA with no sonuc_gecerli_o pulse.
REQ-036 BOLME_ONBELLEK_EN on: DIVU 400/3, then REMU 400/3 -> 1 after edge 1; an intervening iptal_i SHALL force the full 33-cycle latency.
REQ-037 ADIM_BIT=4: DIVU 0xFFFFFFFF/7 -> 0x24924924 after edge 9.
